// File: rtl/axis_eth_fcs_rx_arb.sv
// Frame-granular round-robin arbiter: S_COUNT byte-wide AXI4-Stream sources share one
// registered output with a skid register; a grant is held from the first beat through tlast.
module axis_eth_fcs_rx_arb #(
   parameter int S_COUNT  = 4,
   parameter int ID_WIDTH = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [S_COUNT*8-1:0]   s_axis_tdata,
   input  logic [S_COUNT-1:0]     s_axis_tvalid,
   output logic [S_COUNT-1:0]     s_axis_tready,
   input  logic [S_COUNT-1:0]     s_axis_tlast,
   input  logic [S_COUNT-1:0]     s_axis_tuser,
   output logic [7:0]             m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser,
   output logic [ID_WIDTH-1:0]    m_axis_tid,
   output logic                   busy,
   output logic [ID_WIDTH-1:0]    grant_index
);

   // Handshake: a beat moves on any interface only in a cycle where valid and ready are
   // both high at the rising edge; valid never waits on ready, and ready here is registered.
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t              state;
   logic [ID_WIDTH-1:0] last_grant;
   logic [ID_WIDTH-1:0] start;
   logic [ID_WIDTH-1:0] sel_index;
   logic [ID_WIDTH:0]   cand;
   logic [S_COUNT-1:0]  req_rot;
   logic                sel_found;

   logic                int_ready;
   logic                int_valid;
   logic                ready_early;
   logic                in_valid;
   logic [7:0]          in_data;
   logic                in_last;
   logic                in_user;

   logic                out_valid;
   logic [7:0]          out_data;
   logic                out_last;
   logic                out_user;
   logic [ID_WIDTH-1:0] out_id;
   logic                temp_valid;
   logic [7:0]          temp_data;
   logic                temp_last;
   logic                temp_user;
   logic [ID_WIDTH-1:0] temp_id;

   // Rotate the request vector so bit 0 is the port just after the last winner.
   always_comb begin
      start     = (last_grant == ID_WIDTH'(S_COUNT - 1)) ? '0 : last_grant + 1'b1;
      req_rot   = S_COUNT'({s_axis_tvalid, s_axis_tvalid} >> start);
      sel_found = 1'b0;
      cand      = '0;
      for (int k = 0; k < S_COUNT; k++) begin
         if (!sel_found && req_rot[k]) begin
            sel_found = 1'b1;
            cand      = {1'b0, start} + (ID_WIDTH + 1)'(k);
            if (cand >= (ID_WIDTH + 1)'(S_COUNT)) cand = cand - (ID_WIDTH + 1)'(S_COUNT);
         end
      end
      sel_index = cand[ID_WIDTH-1:0];
   end

   always_comb begin
      in_valid      = 1'b0;
      in_data       = '0;
      in_last       = 1'b0;
      in_user       = 1'b0;
      s_axis_tready = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         if (grant_index == ID_WIDTH'(i)) begin
            in_valid         = s_axis_tvalid[i];
            in_data          = s_axis_tdata[i*8 +: 8];
            in_last          = s_axis_tlast[i];
            in_user          = s_axis_tuser[i];
            s_axis_tready[i] = (state == GRANT) && int_ready;
         end
      end
   end

   assign int_valid   = (state == GRANT) && int_ready && in_valid;
   assign ready_early = m_axis_tready || (!temp_valid && (!out_valid || !int_valid));
   assign busy        = (state == GRANT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant_index <= '0;
         last_grant  <= ID_WIDTH'(S_COUNT - 1);
         int_ready   <= 1'b0;
         out_valid   <= 1'b0;
         temp_valid  <= 1'b0;
      end else begin
         int_ready <= ready_early;
         case (state)
            IDLE: begin
               if (|s_axis_tvalid) begin
                  grant_index <= sel_index;
                  state       <= GRANT;
               end
            end
            GRANT: begin
               if (int_valid && in_last) begin
                  last_grant <= grant_index;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // The skid register only fills when the output is stalled while a beat arrives.
         if (int_ready) begin
            if (m_axis_tready || !out_valid) out_valid <= int_valid;
            else temp_valid <= int_valid;
         end else if (m_axis_tready) begin
            out_valid  <= temp_valid;
            temp_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (int_ready) begin
         if (m_axis_tready || !out_valid) begin
            out_data <= in_data;
            out_last <= in_last;
            out_user <= in_user;
            out_id   <= grant_index;
         end else begin
            temp_data <= in_data;
            temp_last <= in_last;
            temp_user <= in_user;
            temp_id   <= grant_index;
         end
      end else if (m_axis_tready) begin
         out_data <= temp_data;
         out_last <= temp_last;
         out_user <= temp_user;
         out_id   <= temp_id;
      end
   end

   assign m_axis_tvalid = out_valid;
   assign m_axis_tdata  = out_data;
   assign m_axis_tlast  = out_last;
   assign m_axis_tuser  = out_user;
   assign m_axis_tid    = out_id;

endmodule

// File: tb/tb_axis_eth_fcs_rx_arb.sv
// Bench for axis_eth_fcs_rx_arb: a 4-port instance against a frame-level round-robin model
// and scoreboard, plus a 1-port instance for the degenerate register-slice build.
module tb_axis_eth_fcs_rx_arb;
   localparam int S = 4;
   localparam int W = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [S*8-1:0] s_tdata;
   logic [S-1:0]   s_tvalid, s_tready, s_tlast, s_tuser;
   logic [7:0]     m_tdata;
   logic           m_tvalid, m_tready, m_tlast, m_tuser, busy;
   logic [1:0]     m_tid, grant_index;

   logic [7:0]     s1_tdata, m1_tdata;
   logic [0:0]     s1_tvalid, s1_tready, s1_tlast, s1_tuser;
   logic           m1_tvalid, m1_tready, m1_tlast, m1_tuser, busy1;
   logic [0:0]     m1_tid, grant1;

   axis_eth_fcs_rx_arb #(.S_COUNT(S)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tid(m_tid),
      .busy(busy), .grant_index(grant_index)
   );

   axis_eth_fcs_rx_arb #(.S_COUNT(1)) dut1 (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
      .s_axis_tlast(s1_tlast), .s_axis_tuser(s1_tuser),
      .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
      .m_axis_tlast(m1_tlast), .m_axis_tuser(m1_tuser), .m_axis_tid(m1_tid),
      .busy(busy1), .grant_index(grant1)
   );

   logic [W-1:0] exp_q[$];
   logic [9:0]   src_q[S][$];
   logic [S-1:0] en;
   logic [5:0]   pat = 6'b101001;
   int checks = 0, errors = 0, stepn = 0, pat_i = 0, mode = 0;
   bit model_busy = 0, started = 0;
   int model_g = 0, model_last = S - 1;
   int start_port[$], start_step[$], end_step[$], out_step[$];
   int busy_cnt = 0, out_cnt = 0;
   logic last_user = 1'b0;
   bit s1_run = 0;
   int s1_sent = 0, s1_total = 0;
   logic [7:0] s1_next = 8'h00, s1_exp = 8'h00;
   int s1_steps[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input int last, input logic [S-1:0] req);
      for (int k = 1; k <= S; k++) if (req[(last + k) % S]) return (last + k) % S;
      return -1;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < S; i++) if (src_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic push_frame(input int p, input int len, input logic [7:0] base, input logic ulast);
      for (int j = 0; j < len; j++)
         src_q[p].push_back({((j == len - 1) ? ulast : 1'b0), (j == len - 1), 8'(base + 8'(j))});
   endtask

   task automatic drive();
      if (mode == 2) en = 4'($urandom_range(0, 15));
      for (int i = 0; i < S; i++) begin
         if (en[i] && src_q[i].size() > 0) begin
            s_tvalid[i] = 1'b1;
            {s_tuser[i], s_tlast[i], s_tdata[i*8 +: 8]} = src_q[i][0];
         end else begin
            s_tvalid[i] = 1'b0;
            s_tlast[i] = 1'($urandom_range(0, 1));
            s_tuser[i] = 1'b0;
            s_tdata[i*8 +: 8] = 8'($urandom);
         end
      end
      case (mode)
         1: m_tready = pat[pat_i % 6];
         2: m_tready = ($urandom_range(0, 3) != 0);
         default: m_tready = 1'b1;
      endcase
      pat_i++;
      s1_tvalid = (s1_run && s1_sent < s1_total);
      s1_tdata  = s1_next;
      s1_tlast  = 1'b1;
      s1_tuser  = 1'b0;
      m1_tready = 1'b1;
   endtask

   task automatic observe();
      logic [S-1:0] acc;
      logic [9:0] beat;
      logic [W-1:0] e;
      bit nb;
      int p;
      acc = s_tvalid & s_tready;
      nb = model_busy;
      chk("busy", busy, model_busy);
      chk("ready_onehot", ($countones(s_tready) <= 1), 1);
      if (busy) busy_cnt++;
      if (!model_busy) begin
         chk("idle_accept", acc, 0);
         p = rr_pick(model_last, s_tvalid);
         if (p >= 0) begin nb = 1; model_g = p; started = 0; end
      end else begin
         chk("grant_index", grant_index, model_g);
         chk("foreign_accept", acc & ~(4'b0001 << model_g), 0);
         if (acc[model_g]) begin
            beat = src_q[model_g].pop_front();
            exp_q.push_back({2'(model_g), beat});
            if (!started) begin
               start_port.push_back(model_g);
               start_step.push_back(stepn);
               started = 1;
            end
            if (beat[8]) begin
               model_last = model_g;
               nb = 0;
               end_step.push_back(stepn);
            end
         end
      end
      if (m_tvalid && m_tready) begin
         out_step.push_back(stepn);
         out_cnt++;
         if (m_tlast) last_user = m_tuser;
         if (exp_q.size() == 0) chk("unexpected_beat", {m_tid, m_tuser, m_tlast, m_tdata}, 32'hFFFF_FFFF);
         else begin
            e = exp_q.pop_front();
            chk("out_beat", {m_tid, m_tuser, m_tlast, m_tdata}, e);
         end
      end
      if (rst) begin
         nb = 0;
         model_last = S - 1;
         started = 0;
         exp_q.delete();
      end
      model_busy = nb;
      if (s1_tvalid && s1_tready) begin s1_sent++; s1_next++; end
      if (m1_tvalid && m1_tready) begin
         s1_steps.push_back(stepn);
         chk("s1_beat", {m1_tid, m1_tlast, m1_tdata}, {1'b0, 1'b1, s1_exp});
         s1_exp++;
      end
   endtask

   task automatic step();
      drive();
      #1;
      observe();
      @(posedge clk);
      @(negedge clk);
      stepn++;
   endtask

   task automatic run_drain(input int budget, input string tag);
      int n = 0;
      while (n < budget && !(all_empty() && exp_q.size() == 0 && !model_busy)) begin
         step();
         n++;
      end
      chk({tag, "_drained"}, (n < budget), 1);
      step();
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, rise, r1, held, p, len;
      int order[6] = '{0, 1, 3, 0, 1, 3};
      rst = 1'b1;
      en = '0;
      drive();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mvalid", m_tvalid, 0);
      chk("rst_sready", s_tready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_index, 0);
      chk("rst_m1valid", m1_tvalid, 0);
      rst = 1'b0;

      // Single 3-beat frame on port 2 with the output always ready.
      en = '1;
      step();
      step();
      push_frame(2, 3, 8'hA1, 1'b0);
      out_step.delete();
      busy_cnt = 0;
      rise = stepn;
      run_drain(20, "p1");
      chk("p1_first_out", (out_step.size() > 0) ? out_step[0] - rise : -1, 2);
      chk("p1_busy_cycles", busy_cnt, 3);
      chk("p1_out_count", out_step.size(), 3);

      // Ports 0, 1, 3 each with two pending 2-beat frames from reset.
      rst = 1'b1;
      step();
      rst = 1'b0;
      start_port.delete(); start_step.delete(); end_step.delete();
      for (int rep = 0; rep < 2; rep++) begin
         push_frame(0, 2, 8'(8'h00 + rep * 2), rep[0]);
         push_frame(1, 2, 8'(8'h10 + rep * 2), rep[0]);
         push_frame(3, 2, 8'(8'h30 + rep * 2), rep[0]);
      end
      run_drain(60, "p2");
      chk("p2_frames", start_port.size(), 6);
      for (int k = 0; k < start_port.size() && k < 6; k++) chk("p2_order", start_port[k], order[k]);
      for (int k = 0; k + 1 < start_step.size() && k < end_step.size(); k++)
         chk("p2_gap", start_step[k+1] - end_step[k], 2);

      // Port 1 8-byte frame against a toggling output ready.
      mode = 1;
      pat_i = 0;
      out_cnt = 0;
      last_user = 1'b0;
      push_frame(1, 8, 8'h10, 1'b1);
      run_drain(80, "p3");
      chk("p3_out_count", out_cnt, 8);
      chk("p3_last_user", last_user, 1);
      mode = 0;

      // Port 0 stalls mid-frame while port 1 requests.
      start_port.delete();
      push_frame(0, 4, 8'h40, 1'b0);
      n = 0;
      while (src_q[0].size() > 2 && n < 20) begin step(); n++; end
      chk("p4_reach_mid", src_q[0].size(), 2);
      en[0] = 1'b0;
      push_frame(1, 2, 8'h50, 1'b0);
      r1 = 0;
      held = 0;
      repeat (20) begin
         step();
         if (s_tready[1]) r1++;
         if (!busy || grant_index != 2'd0) held++;
      end
      chk("p4_ready1_low", r1, 0);
      chk("p4_grant_held", held, 0);
      en[0] = 1'b1;
      run_drain(40, "p4");
      chk("p4_frames", start_port.size(), 2);
      chk("p4_first", (start_port.size() > 0) ? start_port[0] : -1, 0);
      chk("p4_second", (start_port.size() > 1) ? start_port[1] : -1, 1);

      // Reset pulsed while beat 3 of a 6-beat port-3 frame is presented.
      start_port.delete();
      push_frame(3, 6, 8'h30, 1'b0);
      n = 0;
      while (src_q[3].size() > 4 && n < 20) begin step(); n++; end
      chk("p5_reach_beat3", src_q[3].size(), 4);
      src_q[3].delete();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("p5_mvalid_after_rst", m_tvalid, 0);
      chk("p5_busy_after_rst", busy, 0);
      start_port.delete();
      push_frame(1, 2, 8'h61, 1'b0);
      push_frame(0, 2, 8'h62, 1'b0);
      run_drain(30, "p5");
      chk("p5_first_port", (start_port.size() > 0) ? start_port[0] : -1, 0);

      // Randomized frames, port gaps and output backpressure.
      mode = 2;
      for (int f = 0; f < 14; f++) begin
         p = $urandom_range(0, S - 1);
         len = $urandom_range(1, 5);
         for (int j = 0; j < len; j++)
            src_q[p].push_back({1'($urandom_range(0, 1)), (j == len - 1), 8'($urandom)});
      end
      run_drain(1500, "rand");
      mode = 0;
      en = '1;

      // Single-port build: ten back-to-back single-beat frames.
      s1_run = 1;
      s1_total = 10;
      s1_steps.delete();
      s1_exp = s1_next;
      repeat (30) step();
      chk("s1_count", s1_steps.size(), 10);
      for (int k = 1; k < s1_steps.size(); k++) chk("s1_spacing", s1_steps[k] - s1_steps[k-1], 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/axis_eth_fcs_rx_arb.md
# axis_eth_fcs_rx_arb

Frame-granular round-robin arbiter that shares one 8-bit AXI4-Stream Ethernet datapath, typically the downstream FCS checker, between `S_COUNT` receive sources. A grant is held for a whole frame, from the first beat through the `tlast` beat, so frames are never interleaved. The source index travels with each beat on `m_axis_tid` so downstream logic can steer results back. The output is fully registered with a skid register for full throughput.

## Interface
- `S_COUNT`, 4: number of source ports, 1..16.
- `ID_WIDTH`, `$clog2(S_COUNT)` (min 1): width of `m_axis_tid` and `grant_index`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `s_axis_tdata` in `S_COUNT*8`: port i occupies bits `[i*8+7:i*8]`.
- `s_axis_tvalid` in `S_COUNT`: per-port valid.
- `s_axis_tready` out `S_COUNT`: per-port ready; at most one bit high.
- `s_axis_tlast` in `S_COUNT`: per-port end of frame.
- `s_axis_tuser` in `S_COUNT`: per-port frame-error flag, forwarded unchanged.
- `m_axis_tdata` out 8: shared output data.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: output ready.
- `m_axis_tlast` out 1: output end of frame.
- `m_axis_tuser` out 1: output error flag.
- `m_axis_tid` out `ID_WIDTH`: source index of the current beat.
- `busy` out 1: high while a grant is held.
- `grant_index` out `ID_WIDTH`: index of the currently granted port; only meaningful while `busy` is high.

## Operation
- State `IDLE`:
  - All `s_axis_tready` bits are 0.
  - If any `s_axis_tvalid` bit is high, select the first requesting port when searching from `(last_grant+1) mod S_COUNT` upward with wrap.
  - Load the selection into `grant_index`, go to `GRANT`.
  - `busy` becomes 1 on the same edge.
- State `GRANT` (port g):
  - `s_axis_tready[g]` = registered internal ready. Internal ready is high when the output register or the skid register can accept a beat. All other ready bits are 0.
  - A beat transfers when `s_axis_tvalid[g]` and `s_axis_tready[g]` are both high.
  - Each transferred beat copies data, last and user from port g into the output stage, with `tid = g`.
  - On the transfer carrying `s_axis_tlast[g]`: set `last_grant <= g`, go to `IDLE`, deassert `busy`. `s_axis_tready[g]` drops on the following cycle.
  - If `s_axis_tvalid[g]` drops mid-frame, the grant is held indefinitely. There is no timeout and no other port is served.
- Requests from ports that are not granted are ignored. Their data is not consumed and their `tvalid` may stay high.
- `S_COUNT = 1`: the arbiter degenerates to a frame-gated register slice, always granting port 0.
- Output stage: 2-register slice (output register plus temp/skid register).
  - Internal ready for next cycle = `m_axis_tready || (!temp_valid && (!out_valid || !int_valid))`.
  - No beat is dropped or duplicated under any `m_axis_tready` pattern.
- Reset values: `m_axis_tvalid=0`, `s_axis_tready=0`, `busy=0`, `grant_index=0`, `last_grant=S_COUNT-1` (so port 0 wins first), state `IDLE`, skid register empty.
- `m_axis_tdata`, `tlast`, `tuser` and `tid` are don't-care while `m_axis_tvalid=0`.
- Reset mid-frame: the partial frame is abandoned and nothing further from it is emitted. After reset, arbitration restarts from port 0.

## Timing
- Request to grant: `s_axis_tvalid` seen high in `IDLE` at cycle t gives `busy=1` at t+1. `s_axis_tready[g]` is high at t+1 if the output stage can accept.
- Pass-through latency: a beat accepted at cycle t is on `m_axis` at t+1 when the output register was free.
- Inter-frame gap: one `IDLE` cycle after each `tlast` transfer. Throughput for back-to-back frames is N beats per N+1 cycles.
- Sustained in-frame throughput is 1 beat/cycle with `m_axis_tready` held high.
- When `m_axis_tready` deasserts, at most one extra beat enters the skid register. `s_axis_tready[g]` falls one cycle later.
- A single-beat frame (`tlast` on the first beat) holds the grant for exactly one transfer cycle.

## Test plan
- Reset, then port 2 sends a 3-beat frame `0xA1, 0xA2, 0xA3` (tlast on 3rd), `m_axis_tready=1`:
  - Output `A1, A2, A3` with `tid=2`, tlast on `A3`.
  - First output beat 2 cycles after `tvalid` rose.
  - `busy` is high for 3 cycles.
- Ports 0, 1 and 3 each hold a pending 2-beat frame from reset:
  - Output frame order is 0, 1, 3, 0, ... (port 2 skipped).
  - Exactly one `IDLE` cycle between frames; beats are never interleaved.
- Port 1 frame `0x10..0x17` with `m_axis_tready` toggling 1,0,0,1,0,1, ...:
  - All 8 bytes are delivered in order, once each.
  - tuser on the last beat equals `s_axis_tuser[1]` on its tlast beat.
- Port 0 granted, `s_axis_tvalid[0]` low for 20 cycles mid-frame while port 1 requests:
  - `s_axis_tready[1]` stays 0 throughout.
  - Port 1 is granted only after port 0 transfers its tlast beat.
- `rst` pulsed for one cycle during beat 3 of a 6-beat frame on port 3:
  - From the cycle after reset, no further beats from that frame appear on `m_axis`.
  - `busy=0`.
  - A new request on port 0 is granted first.
- `S_COUNT=1` build, ten back-to-back single-beat frames:
  - Output at 1 frame per 2 cycles, each beat with `tlast=1` and `tid=0`.
